// File: rtl/data_mem_master.sv
// -----------------------------------------------------------------------------
// data_mem_master
//
// Load/store access controller between the execute stage and the processor's
// data memory. Accepts one request at a time, drives the memory strobes for
// 1+WAIT_CYCLES cycles, then returns a registered response.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A source holds valid and its payload stable until that edge;
// ready never depends combinationally on valid.
//
// Optional feature macro: LSU_ADDR_CHECK_EN
//   defined   -> requests with req_addr >= MEM_DEPTH run the full access
//                timing with no memory strobes, return rdata=0 and resp_err=1
//   undefined -> no range check, resp_err is always 0 (memory aliases)
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/ready     request handshake
//   req_we              1 = store, 0 = load
//   req_addr/wdata      word address and store data
//   resp_valid/ready    response handshake
//   resp_rdata          load data (0 for stores / rejected accesses)
//   resp_err            out-of-range address flag
//   mem_access_addr     memory address (holds last latched value)
//   mem_write_data      memory write data (holds last latched value)
//   mem_write_en        single-cycle write strobe on the final access cycle
//   mem_read            read enable, high for every access cycle of a load
//   mem_read_data       combinational memory read data
//   dbg_state           current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
// -----------------------------------------------------------------------------
module data_mem_master #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int MEM_DEPTH   = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

`ifdef LSU_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(MEM_DEPTH);

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [3:0]        r_cnt;
    logic              r_oor;
    logic              r_err;

    logic              w_req_oor;
    logic              w_accept;
    logic              w_final;

    // Constant-folds to 0 when the range check is compiled out.
    assign w_req_oor = ADDR_CHECK && (req_addr >= DEPTH_A);

    // Next state and all outputs; outputs decode registered state only.
    always_comb begin
        w_next          = r_state;
        w_accept        = 1'b0;
        w_final         = 1'b0;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        mem_read        = 1'b0;
        mem_write_en    = 1'b0;
        mem_access_addr = r_addr;
        mem_write_data  = r_wdata;
        resp_rdata      = r_rdata;
        resp_err        = r_err;
        dbg_state       = r_state;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Final access cycle is the one where the wait counter is 0.
                w_final      = (r_cnt == 4'd0);
                mem_read     = !r_we && !r_oor;
                mem_write_en = r_we && !r_oor && w_final;
                if (w_final) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= 4'd0;
            r_oor   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= WAIT_INIT;
                r_oor   <= w_req_oor;
            end else if (r_state == ST_ACCESS && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Response payload is captured once and then held through RESP.
            if (w_final) begin
                r_rdata <= (r_we || r_oor) ? '0 : mem_read_data;
                r_err   <= r_oor;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_master.sv
// -----------------------------------------------------------------------------
// tb_data_mem_master
//
// Three controller instances with WAIT_CYCLES = 0, 1, 2 (instance k uses k
// wait states), each attached to its own 8-word bench memory. A reference
// model (array mdl) tracks what the memory must contain and what every
// response must carry, from the load/store rules alone.
// -----------------------------------------------------------------------------
module tb_data_mem_master;

    localparam int N = 3;
`ifdef LSU_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n           [N];
    logic        req_valid       [N];
    logic        req_ready       [N];
    logic        req_we          [N];
    logic [15:0] req_addr        [N];
    logic [15:0] req_wdata       [N];
    logic        resp_valid      [N];
    logic        resp_ready      [N];
    logic [15:0] resp_rdata      [N];
    logic        resp_err        [N];
    logic [15:0] mem_access_addr [N];
    logic [15:0] mem_write_data  [N];
    logic        mem_write_en    [N];
    logic        mem_read        [N];
    logic [15:0] mem_read_data   [N];
    logic [1:0]  dbg_state       [N];

    logic [15:0] mem [N][8];
    logic [15:0] mdl [N][8];
    logic        mem_init;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [15:0] pre(input int i);
        return 16'h0D34 + 16'(i * 256);   // address 5 holds 0x1234
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        data_mem_master #(
            .DATA_W(16), .ADDR_W(16), .MEM_DEPTH(8), .WAIT_CYCLES(g)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n[g]),
            .req_valid      (req_valid[g]),
            .req_ready      (req_ready[g]),
            .req_we         (req_we[g]),
            .req_addr       (req_addr[g]),
            .req_wdata      (req_wdata[g]),
            .resp_valid     (resp_valid[g]),
            .resp_ready     (resp_ready[g]),
            .resp_rdata     (resp_rdata[g]),
            .resp_err       (resp_err[g]),
            .mem_access_addr(mem_access_addr[g]),
            .mem_write_data (mem_write_data[g]),
            .mem_write_en   (mem_write_en[g]),
            .mem_read       (mem_read[g]),
            .mem_read_data  (mem_read_data[g]),
            .dbg_state      (dbg_state[g])
        );
        assign mem_read_data[g] = mem[g][mem_access_addr[g][2:0]];
    end

    // Bench memories: decode low address bits, write on rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < N; k++) begin
            if (mem_init) begin
                for (int i = 0; i < 8; i++) mem[k][i] <= pre(i);
            end else if (mem_write_en[k]) begin
                mem[k][mem_access_addr[k][2:0]] <= mem_write_data[k];
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: what the response carries and how memory changes.
    function automatic void model_step(input int k, input bit we, input logic [15:0] a,
                                       input logic [15:0] wd, output logic [15:0] rd,
                                       output bit err);
        err = CHK && (a >= 16'd8);
        rd  = (we || err) ? 16'h0 : mdl[k][a % 8];
        if (we && !err) mdl[k][a % 8] = wd;
    endfunction

    // ---------------- driver ----------------
    // One complete transaction with timing, strobe and payload checks.
    task automatic run_txn(input int k, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, input int hold,
                           input logic [15:0] exp_rd, input bit exp_err, input string tag);
        int t;
        int lat;
        int rd_cnt;
        int wr_cnt;
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        t = 0;
        while (!req_ready[k] && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " accept_timeout"}, 32'(t < 40), 32'd1);
        @(negedge clk);                 // cycle 1: first access cycle
        req_valid[k] = 1'b0;
        lat    = 1;
        rd_cnt = 0;
        wr_cnt = 0;
        while (!resp_valid[k] && lat < 40) begin
            rd_cnt += int'(mem_read[k]);
            wr_cnt += int'(mem_write_en[k]);
            @(negedge clk);
            lat++;
        end
        chk({tag, " resp_cycle"}, 32'(lat), 32'(2 + k));
        chk({tag, " read_cycles"}, 32'(rd_cnt), (!we && !exp_err) ? 32'(1 + k) : 32'd0);
        chk({tag, " write_pulses"}, 32'(wr_cnt), (we && !exp_err) ? 32'd1 : 32'd0);
        // Consumer stalls; a competing request is presented meanwhile.
        for (int h = 0; h < hold; h++) begin
            req_valid[k] = 1'b1;
            req_we[k]    = 1'b0;
            chk($sformatf("%s hold%0d resp_valid", tag, h), 32'(resp_valid[k]), 32'd1);
            chk($sformatf("%s hold%0d rdata", tag, h), 32'(resp_rdata[k]), 32'(exp_rd));
            chk($sformatf("%s hold%0d req_ready", tag, h), 32'(req_ready[k]), 32'd0);
            @(negedge clk);
        end
        chk({tag, " rdata"}, 32'(resp_rdata[k]), 32'(exp_rd));
        chk({tag, " err"}, 32'(resp_err[k]), 32'(exp_err));
        chk({tag, " valid_at_hs"}, 32'(resp_valid[k]), 32'd1);
        resp_ready[k] = 1'b1;
        @(negedge clk);
        resp_ready[k] = 1'b0;
        chk({tag, " valid_dropped"}, 32'(resp_valid[k]), 32'd0);
        chk({tag, " ready_after"}, 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b0;            // competing request withdrawn unaccepted
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          hold;
        logic [15:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [15:0] m_rd;
        bit          m_err;
        logic [15:0] ra, rw;
        bit          rwe;
        int          wr;
        int          nacc, nresp, last;
        bit          pend;

        tbl[0] = '{1'b1, 16'd3, 16'h00A5, 0, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 16'd3, 16'h0000, 3, 16'h00A5, 1'b0};
        tbl[2] = '{1'b1, 16'd7, 16'h1111, 0, 16'h0000, 1'b0};
        tbl[3] = '{1'b0, 16'd7, 16'h0000, 0, 16'h1111, 1'b0};
        tbl[4] = '{1'b0, 16'd0, 16'h0000, 0, 16'h0D34, 1'b0};
        tbl[5] = '{1'b1, 16'd9, 16'hFFFF, 0, 16'h0000, CHK};
        tbl[6] = '{1'b0, 16'd1, 16'h0000, 0, CHK ? 16'h0E34 : 16'hFFFF, 1'b0};
        tbl[7] = '{1'b0, 16'd9, 16'h0000, 1, CHK ? 16'h0000 : 16'hFFFF, CHK};

        // ---- reset ----
        mem_init = 1'b1;
        for (int k = 0; k < N; k++) begin
            rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0; resp_ready[k] = 1'b0;
            for (int i = 0; i < 8; i++) mdl[k][i] = pre(i);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst%0d req_ready", k), 32'(req_ready[k]), 32'd1);
            chk($sformatf("rst%0d resp_valid", k), 32'(resp_valid[k]), 32'd0);
            chk($sformatf("rst%0d resp_rdata", k), 32'(resp_rdata[k]), 32'd0);
            chk($sformatf("rst%0d resp_err", k), 32'(resp_err[k]), 32'd0);
            chk($sformatf("rst%0d mem_addr", k), 32'(mem_access_addr[k]), 32'd0);
            chk($sformatf("rst%0d mem_wdata", k), 32'(mem_write_data[k]), 32'd0);
            chk($sformatf("rst%0d mem_we", k), 32'(mem_write_en[k]), 32'd0);
            chk($sformatf("rst%0d mem_rd", k), 32'(mem_read[k]), 32'd0);
            rst_n[k] = 1'b1;
        end
        mem_init = 1'b0;
        @(negedge clk);

        // ---- table on the zero-wait instance ----
        for (int v = 0; v < 8; v++) begin
            model_step(0, tbl[v].we, tbl[v].addr, tbl[v].wdata, m_rd, m_err);
            run_txn(0, tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].hold,
                    tbl[v].exp_rd, tbl[v].exp_err, $sformatf("vec%0d", v));
        end
        chk("alias_mem1", 32'(mem[0][1]), CHK ? 32'h0E34 : 32'hFFFF);

        // ---- two wait states: load preloaded address 5 ----
        model_step(2, 1'b0, 16'd5, 16'h0, m_rd, m_err);
        run_txn(2, 1'b0, 16'd5, 16'h0, 0, 16'h1234, 1'b0, "wc2_load5");

        // ---- reset in the middle of a store (one wait state) ----
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 16'd2; req_wdata[1] = 16'hBEEF;
        chk("rstmid ready", 32'(req_ready[1]), 32'd1);
        @(negedge clk);                 // cycle 1
        req_valid[1] = 1'b0;
        chk("rstmid we_c1", 32'(mem_write_en[1]), 32'd0);
        rst_n[1] = 1'b0;
        @(negedge clk);
        chk("rstmid we_after", 32'(mem_write_en[1]), 32'd0);
        chk("rstmid req_ready", 32'(req_ready[1]), 32'd1);
        chk("rstmid resp_valid", 32'(resp_valid[1]), 32'd0);
        chk("rstmid mem_addr", 32'(mem_access_addr[1]), 32'd0);
        rst_n[1] = 1'b1;
        wr = 0;
        repeat (4) begin
            wr += int'(mem_write_en[1]);
            @(negedge clk);
        end
        chk("rstmid no_write", 32'(wr), 32'd0);
        chk("rstmid mem2", 32'(mem[1][2]), 32'h0F34);

        // ---- back-to-back loads 0..7, consumer always ready ----
        resp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'd0;
        nacc = 0; nresp = 0; last = -1; pend = 1'b0;
        for (int t = 0; t < 60 && nresp < 8; t++) begin
            if (pend) begin
                pend = 1'b0;
                nacc++;
                if (nacc < 8) req_addr[0] = 16'(nacc);
                else req_valid[0] = 1'b0;
            end
            if (resp_valid[0]) begin
                chk($sformatf("b2b rdata%0d", nresp), 32'(resp_rdata[0]), 32'(mdl[0][nresp]));
                if (last >= 0) chk($sformatf("b2b gap%0d", nresp), 32'(cyc - last), 32'd3);
                last = cyc;
                nresp++;
            end
            if (req_valid[0] && req_ready[0]) pend = 1'b1;
            @(negedge clk);
        end
        resp_ready[0] = 1'b0; req_valid[0] = 1'b0;
        chk("b2b count", 32'(nresp), 32'd8);
        @(negedge clk);

        // ---- random traffic against the model ----
        for (int k = 0; k < N; k++) begin
            for (int r = 0; r < 15; r++) begin
                rwe = 1'($urandom_range(0, 1));
                ra  = 16'($urandom_range(0, 11));
                rw  = 16'($urandom);
                model_step(k, rwe, ra, rw, m_rd, m_err);
                run_txn(k, rwe, ra, rw, int'($urandom_range(0, 2)), m_rd, m_err,
                        $sformatf("rnd%0d_%0d", k, r));
            end
        end

        // ---- final memory contents ----
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 8; i++)
                chk($sformatf("mem%0d[%0d]", k, i), 32'(mem[k][i]), 32'(mdl[k][i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_master.md
# data_mem_master

Load/store access controller that initiates transactions towards the processor's data memory on behalf of the datapath. It accepts one load or store request at a time over a valid/ready handshake and drives the memory-side address, write-data, write-enable and read-enable lines. It then returns a registered response (load data or store acknowledge) over a second valid/ready handshake. It sits between the execute stage and the data memory, in the same clock domain.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 16, address width
- MEM_DEPTH, 8, number of implemented memory words; addresses ≥ MEM_DEPTH are out of range
- WAIT_CYCLES, 0, extra memory wait states per access (0..15)

- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  store data
- resp_valid  output  1  response present
- resp_ready  input  1  consumer takes response
- resp_rdata  output  DATA_W  load data; 0 for stores
- resp_err  output  1  out-of-range address (only with LSU_ADDR_CHECK_EN)
- mem_access_addr  output  ADDR_W  memory address
- mem_write_data  output  DATA_W  memory write data
- mem_write_en  output  1  memory write strobe, sampled by memory on rising clk
- mem_read  output  1  memory read enable
- mem_read_data  input  DATA_W  combinational memory read data

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset → IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_we/req_addr/req_wdata into registers, load wait counter with WAIT_CYCLES, → ACCESS.
- ACCESS: mem_access_addr and mem_write_data are driven from latched registers. For a load, mem_read=1 for every ACCESS cycle. Counter decrements each cycle; the final cycle is the one where counter==0.
  - Load: on the final cycle, register mem_read_data into resp_rdata.
  - Store: mem_write_en=1 on the final cycle only (exactly one pulse per store). resp_rdata is set to 0.
  - → RESP after the final cycle.
- RESP: resp_valid=1; resp_rdata/resp_err are held stable until resp_ready. On resp_valid&&resp_ready → IDLE, resp_valid drops next cycle.
- One outstanding transaction. req_ready=0 in ACCESS and RESP. Requests presented then are not accepted and must be held by the source.
- mem_access_addr and mem_write_data hold the last latched values in IDLE/RESP. mem_read=0 and mem_write_en=0 outside ACCESS.
- Reset while rst_n=0 at a rising edge: state → IDLE, access aborted. No mem_write_en is asserted in the cycle following the reset edge. Any pending response is discarded.

## Timing
- Reset values (after reset edge): req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_access_addr=0, mem_write_data=0, mem_write_en=0, mem_read=0.
- The handshake is accepted in cycle 0. ACCESS occupies cycles 1..1+WAIT_CYCLES. resp_valid rises in cycle 2+WAIT_CYCLES.
- With resp_ready tied 1, throughput is one transaction per 3+WAIT_CYCLES cycles. The next accept is possible in cycle 3+WAIT_CYCLES.
- A store's memory write takes effect at the rising edge ending cycle 1+WAIT_CYCLES. A load issued after a store's response observes the stored data.
- All outputs are registered or decoded from registered state only. There is no combinational path from req_* or resp_ready to any output.

## Configuration
- LSU_ADDR_CHECK_EN defined: a request with req_addr ≥ MEM_DEPTH still runs the full ACCESS timing, but:
  - mem_write_en and mem_read stay 0;
  - resp_rdata=0;
  - resp_err=1 in RESP.
- LSU_ADDR_CHECK_EN undefined: no check is performed; resp_err is tied 0. The memory decodes the low address bits, so out-of-range addresses alias (e.g. 9 → 1).

## Test plan
- Store 0x00A5 to addr 3, then load addr 3, WAIT_CYCLES=0 → mem_write_en pulses once in cycle 1. Store resp_valid rises in cycle 2 with resp_rdata=0. Load response resp_rdata=0x00A5.
- WAIT_CYCLES=2, load addr 5 preloaded with 0x1234 → mem_read high in cycles 1–3. resp_valid rises in cycle 4 with resp_rdata=0x1234.
- Load response with resp_ready low for 3 cycles → resp_valid/resp_rdata held stable for the whole hold. req_ready=0 throughout the hold. A concurrent req_valid is not accepted until the cycle after the resp handshake.
- Store 0xBEEF to addr 2 with rst_n=0 at the edge ending cycle 1 (WAIT_CYCLES=1) → no mem_write_en pulse. Memory[2] is unchanged. req_ready=1 and resp_valid=0 after reset.
- LSU_ADDR_CHECK_EN defined, store 0xFFFF to addr 9 → resp_err=1, mem_write_en never asserted, memory[1] unchanged. Undefined: resp_err=0 and memory[1]=0xFFFF.
- Back-to-back loads of addrs 0..7 with resp_ready=1 → one response every 3 cycles, in order, with data matching the preloaded contents.
